// File: rtl/delay_pkg.sv
// Shared types and constants for the echo/delay controller.
package delay_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int GAIN_WIDTH_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MIX   = 3'd2,
    ST_OUT   = 3'd3,
    ST_CLEAR = 3'd4
  } state_e;

  // Saturation bounds of a w-bit two's complement sample.
  function automatic int sat_hi(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/delay_line_ctrl_sat_mac.sv
// Combinational acc + floor(x*g / 2**GAIN_WIDTH), saturated to the sample range.
module sat_mac
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int GAIN_WIDTH = GAIN_WIDTH_DEF
) (
  input  logic signed [DATA_WIDTH-1:0] acc,
  input  logic signed [DATA_WIDTH-1:0] x,
  input  logic        [GAIN_WIDTH-1:0] g,
  output logic signed [DATA_WIDTH-1:0] y
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH + 1;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] HI = SW'(sat_hi(DATA_WIDTH));
  localparam logic signed [SW-1:0] LO = SW'(sat_lo(DATA_WIDTH));

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shr;
  logic signed [SW-1:0] sum;

  always_comb begin
    // Gain is unsigned: zero-extend it so the signed multiply stays exact.
    prod = $signed({{(GAIN_WIDTH+1){x[DATA_WIDTH-1]}}, x})
         * $signed({{(DATA_WIDTH+1){1'b0}}, g});
    shr  = prod >>> GAIN_WIDTH;
    sum  = $signed({{(SW-DATA_WIDTH){acc[DATA_WIDTH-1]}}, acc}) + $signed({shr[PW-1], shr});
    if (sum > HI)      y = HI[DATA_WIDTH-1:0];
    else if (sum < LO) y = LO[DATA_WIDTH-1:0];
    else               y = sum[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/delay_line_ctrl.sv
// Echo/delay controller driving an external dual-port sample BRAM.
// Optional DELAY_CLEAR_EN zero-fills the whole buffer after reset.
module delay_line_ctrl
  import delay_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int GAIN_WIDTH = GAIN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [ADDR_WIDTH-1:0] delay_len,
  input  logic [GAIN_WIDTH-1:0] fb_gain,
  input  logic [GAIN_WIDTH-1:0] mix_gain,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic [ADDR_WIDTH-1:0] ram_dpra,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_dpo
);

`ifdef DELAY_CLEAR_EN
  localparam state_e RST_STATE = ST_CLEAR;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic signed [DATA_WIDTH-1:0] out_q, out_d;
  logic signed [DATA_WIDTH-1:0] in_q;
  logic [ADDR_WIDTH-1:0]   dlen_q;
  logic [GAIN_WIDTH-1:0]   fb_q, mix_q;
  logic signed [DATA_WIDTH-1:0] dly, fb_sum, mix_sum;
  logic                    hs;

  assign hs  = in_valid & in_ready;
  // A zero delay would read back the slot about to be overwritten; force dry.
  assign dly = (dlen_q == '0) ? '0 : $signed(ram_dpo);

  sat_mac #(.DATA_WIDTH(DATA_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_fb (
    .acc(in_q), .x(dly), .g(fb_q), .y(fb_sum)
  );

  sat_mac #(.DATA_WIDTH(DATA_WIDTH), .GAIN_WIDTH(GAIN_WIDTH)) u_mix (
    .acc(in_q), .x(dly), .g(mix_q), .y(mix_sum)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= RST_STATE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hs) state_d = ST_READ;
      ST_READ:  state_d = ST_MIX;
      ST_MIX:   state_d = ST_OUT;
      ST_OUT:   if (out_ready) state_d = ST_IDLE;
`ifdef DELAY_CLEAR_EN
      ST_CLEAR: if (&wr_ptr_q) state_d = ST_IDLE;
`endif
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
    out_data  = out_q;
    ram_we    = 1'b0;
    ram_a     = '0;
    ram_dpra  = '0;
    ram_di    = '0;
    case (state_q)
      ST_READ: ram_dpra = wr_ptr_q - dlen_q;
      // Reset during the write cycle must suppress the write.
      ST_MIX: begin
        ram_we = ~reset;
        ram_a  = wr_ptr_q;
        ram_di = fb_sum;
      end
`ifdef DELAY_CLEAR_EN
      ST_CLEAR: begin
        ram_we = ~reset;
        ram_a  = wr_ptr_q;
      end
`endif
      default: ;
    endcase
  end

  // The write pointer doubles as the address counter while clearing; it wraps back to 0.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    out_d    = out_q;
    if (state_q == ST_MIX || state_q == ST_CLEAR) wr_ptr_d = wr_ptr_q + 1'b1;
    if (state_q == ST_MIX) out_d = mix_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      out_q    <= out_d;
    end
    if (hs) begin
      in_q   <= $signed(in_data);
      dlen_q <= delay_len;
      fb_q   <= fb_gain;
      mix_q  <= mix_gain;
    end
  end

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl with a behavioural 16-entry registered-read BRAM.
module tb_delay_line_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic signed [15:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] out_data;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         delay_len;
  logic [7:0]         fb_gain, mix_gain;
  logic               ram_we;
  logic [3:0]         ram_a, ram_dpra;
  logic signed [15:0] ram_di;
  logic [15:0]        ram_dpo;

  logic [15:0] mem [16];
  logic [3:0]  dpra_q;
  logic        mem_clr;
  logic [15:0] mem_val;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  delay_line_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .GAIN_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .delay_len(delay_len), .fb_gain(fb_gain), .mix_gain(mix_gain),
    .ram_we(ram_we), .ram_a(ram_a), .ram_dpra(ram_dpra),
    .ram_di(ram_di), .ram_dpo(ram_dpo)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= mem_val;
    end else if (ram_we) begin
      mem[ram_a] <= ram_di;
    end
    dpra_q <= ram_dpra;
  end
  assign ram_dpo = mem[dpra_q];

  typedef struct {
    bit rst;
    int din;
    int dlen;
    int fb;
    int mix;
    int exp_out;
    int exp_di;
    int exp_a;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input bit rst, input int din, input int dlen, input int fb,
                              input int mix, input int eo, input int ed, input int ea);
    vec_t r;
    r.rst = rst; r.din = din; r.dlen = dlen; r.fb = fb; r.mix = mix;
    r.exp_out = eo; r.exp_di = ed; r.exp_a = ea;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset(input logic [15:0] fill);
    @(negedge clk);
    reset = 1'b1; mem_clr = 1'b1; mem_val = fill; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    mem_clr = 1'b0;
`ifdef DELAY_CLEAR_EN
    chk("rst_in_ready", in_ready, 0);
`else
    chk("rst_in_ready", in_ready, 1);
`endif
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_a", ram_a, 0);
    chk("rst_ram_dpra", ram_dpra, 0);
    chk("rst_ram_di", ram_di, 0);
    reset = 1'b0;
  endtask

  // Handshake one sample, then check latency, the single write and the output.
  task automatic send(input vec_t r, input string tag);
    int k, lat, we_n, di_s, a_s;
    k = 0;
    while (!in_ready && k < 40) begin @(negedge clk); k++; end
    chk({tag, "_in_ready"}, in_ready, 1);
    in_data = 16'(r.din); delay_len = 4'(r.dlen);
    fb_gain = 8'(r.fb); mix_gain = 8'(r.mix); in_valid = 1'b1;
    @(negedge clk);
    // Scramble inputs after the handshake: they must have been latched.
    in_valid = 1'b0; in_data = 16'sh7fff; fb_gain = 8'hff; mix_gain = 8'hff; delay_len = 4'd7;
    lat = 1; we_n = 0; di_s = 0; a_s = -1;
    while (!out_valid && lat < 10) begin
      if (ram_we) begin we_n++; di_s = ram_di; a_s = ram_a; end
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_we_count"}, we_n, 1);
    chk({tag, "_ram_di"}, di_s, r.exp_di);
    chk({tag, "_ram_a"}, a_s, r.exp_a);
    chk({tag, "_out_data"}, out_data, r.exp_out);
  endtask

  initial begin
    int eo_tail[5];
    int cnt;
    int nz;
    eo_tail = '{1699, 1899, 2098, 2298, 2498};

    reset = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    delay_len = '0; fb_gain = '0; mix_gain = '0; mem_clr = 1'b1; mem_val = '0;

    // Bypass
    vt.push_back(mk(1, 1000, 0, 0, 255, 1000, 1000, 0));
    vt.push_back(mk(0, -5, 0, 255, 255, -5, -5, 1));
    // Echo impulse, delay 3, mix 1/2
    vt.push_back(mk(1, 1000, 3, 0, 128, 1000, 1000, 0));
    vt.push_back(mk(0, 0, 3, 0, 128, 0, 0, 1));
    vt.push_back(mk(0, 0, 3, 0, 128, 0, 0, 2));
    vt.push_back(mk(0, 0, 3, 0, 128, 500, 0, 3));
    vt.push_back(mk(0, 0, 3, 0, 128, 0, 0, 4));
    // Floor rounding of negative products
    vt.push_back(mk(1, -3, 1, 128, 128, -3, -3, 0));
    vt.push_back(mk(0, 0, 1, 128, 128, -2, -2, 1));
    vt.push_back(mk(0, 0, 1, 128, 128, -1, -1, 2));
    vt.push_back(mk(0, 0, 1, 128, 128, -1, -1, 3));
    // Positive and negative saturation
    vt.push_back(mk(1, 30000, 1, 255, 255, 30000, 30000, 0));
    vt.push_back(mk(0, 30000, 1, 255, 255, 32767, 32767, 1));
    vt.push_back(mk(0, 30000, 1, 255, 255, 32767, 32767, 2));
    vt.push_back(mk(1, -30000, 1, 255, 255, -30000, -30000, 0));
    vt.push_back(mk(0, -30000, 1, 255, 255, -32768, -32768, 1));
    vt.push_back(mk(0, -30000, 1, 255, 255, -32768, -32768, 2));
    // Pointer wrap with the maximum delay
    for (int n = 0; n < 20; n++)
      vt.push_back(mk(n == 0, 100 * (n + 1), 15, 0, 255,
                      (n < 15) ? 100 * (n + 1) : eo_tail[n - 15], 100 * (n + 1), n % 16));
    // Zero delay must ignore the stale sample sitting at the write slot
    vt.push_back(mk(0, 10, 0, 255, 255, 10, 10, 4));

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset(16'h0000);
      send(vt[i], $sformatf("vec%0d", i));
    end

    // Backpressure: output held, no input accepted, no writes
    do_reset(16'h0000);
    out_ready = 1'b0;
    send(mk(0, 1234, 0, 0, 0, 1234, 1234, 0), "bp");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 1234);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_ram_we", ram_we, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);

    // Reset while in MIX aborts the sample
    do_reset(16'h0000);
    cnt = 0;
    while (!in_ready && cnt < 40) begin @(negedge clk); cnt++; end
    in_data = 16'sd777; delay_len = 4'd0; fb_gain = 8'd0; mix_gain = 8'd255; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rm_we_before", ram_we, 1);
    reset = 1'b1;
    #1;
    chk("rm_we_gated", ram_we, 0);
    @(negedge clk);
    chk("rm_out_valid", out_valid, 0);
    chk("rm_out_data", out_data, 0);
    chk("rm_mem0", mem[0], 0);
    reset = 1'b0;
    send(mk(0, 5, 0, 0, 0, 5, 5, 0), "rm_after");

`ifdef DELAY_CLEAR_EN
    // Buffer is zero-filled after reset, so the first echo sees only silence
    do_reset(16'h5a5a);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (ram_we) begin
        chk("clr_addr", ram_a, cnt % 16);
        chk("clr_di", ram_di, 0);
        chk("clr_in_ready", in_ready, 0);
        cnt++;
      end else if (in_ready) begin
        break;
      end
      @(negedge clk);
    end
    chk("clr_count", cnt, 16);
    nz = 0;
    for (int i = 0; i < 16; i++) if (mem[i] != 16'h0000) nz++;
    chk("clr_nonzero", nz, 0);
    send(mk(0, 1000, 3, 255, 255, 1000, 1000, 0), "clr_e0");
    send(mk(0, 0, 3, 255, 255, 0, 0, 1), "clr_e1");
    send(mk(0, 0, 3, 255, 255, 0, 0, 2), "clr_e2");
    send(mk(0, 0, 3, 255, 255, 996, 996, 3), "clr_e3");
`else
    nz = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
